// File: rtl/ray_job_dispatcher.sv
// ray_job_dispatcher: splits a frame into fixed-width pixel-run jobs, issues
// them in raster order over valid/ready, and limits jobs in flight using
// completion credits.
module ray_job_dispatcher #(
    parameter int JOBS             = 640,
    parameter int JOBS_SUBDIVISION = 64,
    parameter int ROWS             = 480,
    parameter int MAX_OUTSTANDING  = 10,
    localparam int XW = $clog2(JOBS),
    localparam int YW = $clog2(ROWS),
    localparam int IW = $clog2((JOBS / JOBS_SUBDIVISION) * ROWS),
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          frame_start,
    output logic          job_valid,
    input  logic          job_ready,
    output logic [XW-1:0] job_x,
    output logic [YW-1:0] job_y,
    output logic [IW-1:0] job_idx,
    input  logic          job_done,
    output logic          busy,
    output logic          frame_done,
    output logic          credit_err
);

    localparam logic [XW-1:0] LAST_X   = XW'(JOBS - JOBS_SUBDIVISION);
    localparam logic [YW-1:0] LAST_Y   = YW'(ROWS - 1);
    localparam logic [XW-1:0] X_STEP   = XW'(JOBS_SUBDIVISION);
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state, state_next;
    logic [OW-1:0] outstanding, outstanding_next;
    logic          credit_err_next;
    logic          xfer;
    logic          last_job;

    // Handshake decode: a transfer, and whether it carries the frame's final job.
    always_comb begin
        xfer     = job_valid && job_ready;
        last_job = xfer && (job_x == LAST_X) && (job_y == LAST_Y);
    end

    // Credit counter: a same-cycle issue and completion cancel; a completion
    // with nothing in flight is dropped and flagged instead of underflowing.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        outstanding_next = outstanding;
        credit_err_next  = credit_err;
        if (xfer && !job_done) begin
            outstanding_next = outstanding + 1'b1;
        end else if (job_done && !xfer) begin
            if (outstanding == '0) begin
                credit_err_next = 1'b1;
            end else begin
                outstanding_next = outstanding - 1'b1;
            end
        end
    end

    // Next-state logic; DRAIN looks at the post-update credit count so a
    // completion arriving this cycle can finish the frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start)             state_next = ISSUE;
            ISSUE:   if (last_job)                state_next = DRAIN;
            DRAIN:   if (outstanding_next == '0)  state_next = DONE;
            DONE:                                 state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    // State, credits, sticky error and the registered valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            outstanding <= '0;
            credit_err  <= 1'b0;
            job_valid   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state       <= state_next;
            outstanding <= outstanding_next;
            credit_err  <= credit_err_next;
            // Valid is computed from next-cycle state and credits; it can only
            // fall on a transfer (credits only shrink otherwise), so it never
            // drops while a job is waiting on ready.
            job_valid   <= (state_next == ISSUE) && (outstanding_next < OUT_MAX);
        end
    end

    // Job payload: cleared on frame entry, advanced in raster order per transfer,
    // held otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            job_x   <= '0;
            job_y   <= '0;
            job_idx <= '0;
        end else if (state == IDLE && frame_start) begin
            job_x   <= '0;
            job_y   <= '0;
            job_idx <= '0;
        end else if (xfer) begin
            job_idx <= job_idx + 1'b1;
            if (job_x == LAST_X) begin
                job_x <= '0;
                job_y <= job_y + 1'b1;
            end else begin
                job_x <= job_x + X_STEP;
            end
        end
    end

    assign busy       = (state == ISSUE) || (state == DRAIN);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_ray_job_dispatcher.sv
// tb_ray_job_dispatcher: directed and randomized stimulus against a
// count-based reference model of the job dispatcher.
module tb_ray_job_dispatcher;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;
    localparam int NJOBS   = 4800;
    localparam int JPR     = 10;
    localparam int SUB     = 64;
    localparam int MAXO    = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        frame_start = 1'b0;
    logic        job_ready = 1'b0;
    logic        job_done = 1'b0;
    logic        job_valid;
    logic [9:0]  job_x;
    logic [8:0]  job_y;
    logic [12:0] job_idx;
    logic        busy;
    logic        frame_done;
    logic        credit_err;

    ray_job_dispatcher dut (
        .clk         (clk),
        .rstn        (rstn),
        .frame_start (frame_start),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_x       (job_x),
        .job_y       (job_y),
        .job_idx     (job_idx),
        .job_done    (job_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .credit_err  (credit_err)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: frame phase, jobs issued, jobs in flight, sticky error.
    int m_phase;
    int m_n;
    int m_out;
    bit m_cerr;
    bit m_valid;
    int xfers;
    int fdones;
    int last_x;
    int last_y;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_n     = 0;
        m_out   = 0;
        m_cerr  = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(job_valid), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_fdone"}, 32'(frame_done), 0);
        check({tag, "_cerr"},  32'(credit_err), 0);
        check({tag, "_x"},     32'(job_x), 0);
        check({tag, "_y"},     32'(job_y), 0);
        check({tag, "_idx"},   32'(job_idx), 0);
    endtask

    // One clock: drive inputs, advance the model by the edge, compare outputs.
    task automatic cyc(input bit fs, input bit rdy, input bit dn);
        bit x;
        int prev;
        frame_start = fs;
        job_ready   = rdy;
        job_done    = dn;
        x = m_valid && rdy;
        if (x) begin
            last_x = int'(job_x);
            last_y = int'(job_y);
        end
        @(posedge clk);
        #1;
        prev = m_phase;
        if (x) begin
            m_n++;
            xfers++;
        end
        if (x && !dn)       m_out++;
        else if (dn && !x) begin
            if (m_out == 0) m_cerr = 1'b1;
            else            m_out--;
        end
        case (prev)
            P_IDLE:  if (fs) begin m_phase = P_ISSUE; m_n = 0; end
            P_ISSUE: if (x && m_n == NJOBS) m_phase = P_DRAIN;
            P_DRAIN: if (m_out == 0) m_phase = P_DONE;
            default: m_phase = P_IDLE;
        endcase
        m_valid = (m_phase == P_ISSUE) && (m_out < MAXO);
        if (m_phase == P_DONE) fdones++;
        check("valid", 32'(job_valid), m_valid);
        check("busy",  32'(busy), (m_phase == P_ISSUE || m_phase == P_DRAIN) ? 1 : 0);
        check("frame_done", 32'(frame_done), (m_phase == P_DONE) ? 1 : 0);
        check("credit_err", 32'(credit_err), m_cerr);
        if (m_valid) begin
            check("idx", 32'(job_idx), m_n);
            check("x",   32'(job_x), (m_n % JPR) * SUB);
            check("y",   32'(job_y), m_n / JPR);
        end
    endtask

    initial begin
        bit       rdy;
        bit       dn;
        bit       fs;
        bit       xf;
        bit       fin;
        bit       seen10;
        int       hold;
        logic [1:0] dpipe;

        xfers  = 0;
        fdones = 0;
        last_x = -1;
        last_y = -1;
        model_reset();

        // Reset state.
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Stray completion in IDLE sets the sticky error, no underflow.
        cyc(0, 0, 1);
        check("cerr_idle", 32'(credit_err), 1);
        cyc(0, 0, 0);

        // Frame A: ready high, completions 2 cycles after each transfer,
        // ready held low for 5 cycles while job 9 is offered.
        dpipe  = 2'b00;
        hold   = 0;
        seen10 = 1'b0;
        fin    = 1'b0;
        xfers  = 0;
        cyc(1, 0, 0);
        for (int k = 0; k < 8000 && !fin; k++) begin
            rdy = !(m_valid && m_n == 9 && hold < 5);
            if (m_valid && m_n == 9 && !rdy) hold++;
            dn = dpipe[1];
            xf = m_valid && rdy;
            cyc(0, rdy, dn);
            dpipe = {dpipe[0], xf};
            if (m_valid && m_n == 10 && !seen10) begin
                seen10 = 1'b1;
                check("wrap_x", 32'(job_x), 0);
                check("wrap_y", 32'(job_y), 1);
                check("wrap_idx", 32'(job_idx), 10);
            end
            if (m_phase == P_DONE) fin = 1'b1;
        end
        check("frameA_timeout", 32'(fin), 1);
        check("hold_cycles", 32'(hold), 5);
        check("frameA_xfers", 32'(xfers), NJOBS);
        check("frameA_fdones", 32'(fdones), 1);
        check("last_x", 32'(last_x), 576);
        check("last_y", 32'(last_y), 479);
        cyc(0, 0, 0);
        check("busy_after", 32'(busy), 0);

        // Frame B: credit limit.
        xfers = 0;
        cyc(1, 1, 0);
        repeat (14) cyc(0, 1, 0);
        check("limit_xfers", 32'(xfers), 10);
        check("limit_valid", 32'(job_valid), 0);
        cyc(0, 1, 1);
        repeat (5) cyc(0, 1, 0);
        check("one_more_xfer", 32'(xfers), 11);
        cyc(0, 0, 1);
        check("valid_reopen", 32'(job_valid), 1);
        cyc(0, 1, 1);
        check("same_cycle_valid", 32'(job_valid), 1);
        check("same_cycle_xfers", 32'(xfers), 12);
        // frame_start mid-ISSUE must not restart.
        cyc(1, 0, 0);
        check("restart_ignored_idx", 32'(job_idx), 12);

        // Remainder of frame B under random ready/done/frame_start.
        fin = 1'b0;
        for (int k = 0; k < 40000 && !fin; k++) begin
            rdy = ($urandom_range(0, 3) != 0);
            dn  = (m_out > 0) && ($urandom_range(0, 1) == 1);
            fs  = ($urandom_range(0, 99) == 0);
            cyc(fs, rdy, dn);
            if (m_phase == P_DONE) fin = 1'b1;
        end
        check("frameB_timeout", 32'(fin), 1);
        check("frameB_xfers", 32'(xfers), NJOBS);
        check("frameB_fdones", 32'(fdones), 2);
        cyc(0, 0, 0);

        // Frame C: abort with reset at job 2000.
        dpipe = 2'b00;
        fin   = 1'b0;
        cyc(1, 1, 0);
        for (int k = 0; k < 4000 && !fin; k++) begin
            if (m_valid && m_n == 2000) begin
                fin = 1'b1;
            end else begin
                dn = dpipe[1];
                xf = m_valid;
                cyc(0, 1, dn);
                dpipe = {dpipe[0], xf};
            end
        end
        check("frameC_timeout", 32'(fin), 1);
        check("abort_idx", 32'(job_idx), 2000);
        rstn = 1'b0;
        #1;
        check_reset_outputs("abort");
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        // Late completion from the aborted frame.
        cyc(0, 0, 1);
        check("late_done_cerr", 32'(credit_err), 1);
        cyc(1, 1, 0);
        check("restart_valid", 32'(job_valid), 1);
        check("restart_idx", 32'(job_idx), 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
